matmul_sequencer: RTL and testbench

- Top-level controller for the UART matrix-multiply datapath.
- Parses the UART byte stream: a size byte, then matrix A, then matrix B.
- Writes A and B into the A/B matrix memories, starts the Calculator, waits for completion, then streams the result matrix back through uart_tx byte by byte.
- Replaces the ad-hoc addressing and state logic currently in the top level; all memory, calculator and TX handshakes are owned here.

---
 rtl/matmul_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Top-level sequencer for the UART matrix-multiply datapath.
// Parses size/A/B from the RX byte stream, fills the A/B memories, kicks the
// calculator and streams the result matrix back over uart_tx, MSB byte first.
module matmul_sequencer #(
  parameter int unsigned MaxN  = 3,
  parameter int unsigned DataW = 8,
  parameter int unsigned ResW  = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             tx_busy_i,
  output logic             tx_start_o,
  output logic [7:0]       tx_data_o,
  output logic             a_we_o,
  output logic             b_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  output logic             calc_start_o,
  input  logic             calc_done_i,
  output logic [AddrW-1:0] res_addr_o,
  input  logic [ResW-1:0]  res_data_i,
  output logic [3:0]       matrix_size_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             size_err_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StClear    = 3'd1,
    StRxA      = 3'd2,
    StRxB      = 3'd3,
    StCompute  = 3'd4,
    StSend     = 3'd5,
    StSendWait = 3'd6
  } state_e;

  localparam logic [AddrW-1:0] ClrLast = AddrW'(MaxN * MaxN - 1);
  // Cycles to wait for tx_busy to rise before assuming the byte went out.
  localparam logic [1:0]       TmoLast = 2'd3;

  state_e           state_q;
  logic             tx_start_q, a_we_q, b_we_q, calc_start_q, busy_q, size_err_q;
  logic [7:0]       tx_data_q;
  logic [AddrW-1:0] mem_addr_q, res_addr_q;
  logic [DataW-1:0] mem_wdata_q;
  logic [3:0]       matrix_size_q, row_q, col_q;
  logic             hi_q, rd_wait_q, seen_q;
  logic [1:0]       tmo_q;

  logic [3:0]       n_m1, nxt_row, nxt_col;
  logic             last_col, last_elem, size_ok, byte_done;
  logic [AddrW-1:0] cur_idx, nxt_idx;

  // Element position bookkeeping shared by the RX and SEND phases.
  always_comb begin
    n_m1      = matrix_size_q - 4'd1;
    last_col  = (col_q == n_m1);
    last_elem = last_col && (row_q == n_m1);
    nxt_col   = last_col ? 4'd0 : col_q + 4'd1;
    nxt_row   = last_col ? row_q + 4'd1 : row_q;
    cur_idx   = AddrW'(32'(row_q) * MaxN + 32'(col_q));
    nxt_idx   = AddrW'(32'(nxt_row) * MaxN + 32'(nxt_col));
    size_ok   = (rx_data_i != 8'd0) && (32'(rx_data_i) <= MaxN);
    byte_done = !tx_busy_i && (seen_q || (tmo_q == TmoLast));
  end

  // Main sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      a_we_q        <= 1'b0;
      b_we_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      calc_start_q  <= 1'b0;
      res_addr_q    <= '0;
      matrix_size_q <= '0;
      busy_q        <= 1'b0;
      size_err_q    <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      hi_q          <= 1'b0;
      rd_wait_q     <= 1'b0;
      seen_q        <= 1'b0;
      tmo_q         <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      calc_start_q <= 1'b0;
      a_we_q       <= 1'b0;
      b_we_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid_i) begin
            if (size_ok) begin
              matrix_size_q <= rx_data_i[3:0];
              size_err_q    <= 1'b0;
              busy_q        <= 1'b1;
              a_we_q        <= 1'b1;
              b_we_q        <= 1'b1;
              mem_addr_q    <= '0;
              mem_wdata_q   <= '0;
              state_q       <= StClear;
            end else begin
              size_err_q <= 1'b1;
            end
          end
        end
        StClear: begin
          if (mem_addr_q == ClrLast) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= StRxA;
          end else begin
            a_we_q     <= 1'b1;
            b_we_q     <= 1'b1;
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        StRxA, StRxB: begin
          if (rx_valid_i) begin
            a_we_q      <= (state_q == StRxA);
            b_we_q      <= (state_q == StRxB);
            mem_addr_q  <= cur_idx;
            mem_wdata_q <= DataW'(rx_data_i);
            if (last_elem) begin
              row_q <= '0;
              col_q <= '0;
              if (state_q == StRxA) begin
                state_q <= StRxB;
              end else begin
                state_q      <= StCompute;
                calc_start_q <= 1'b1;
              end
            end else begin
              row_q <= nxt_row;
              col_q <= nxt_col;
            end
          end
        end
        StCompute: begin
          // A done flag coinciding with our own start pulse is stale.
          if (calc_done_i && !calc_start_q) begin
            state_q    <= StSend;
            hi_q       <= 1'b1;
            rd_wait_q  <= 1'b1;
            res_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
          end
        end
        StSend: begin
          if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
          end else if (!tx_busy_i) begin
            tx_data_q  <= hi_q ? res_data_i[ResW-1 -: 8] : res_data_i[7:0];
            tx_start_q <= 1'b1;
            seen_q     <= 1'b0;
            tmo_q      <= '0;
            state_q    <= StSendWait;
          end
        end
        StSendWait: begin
          if (tx_busy_i) begin
            seen_q <= 1'b1;
          end else if (byte_done) begin
            if (hi_q) begin
              hi_q    <= 1'b0;
              state_q <= StSend;
            end else begin
              hi_q <= 1'b1;
              if (last_elem) begin
                row_q   <= '0;
                col_q   <= '0;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                row_q      <= nxt_row;
                col_q      <= nxt_col;
                res_addr_q <= nxt_idx;
                rd_wait_q  <= 1'b1;
                state_q    <= StSend;
              end
            end
          end else begin
            tmo_q <= tmo_q + 2'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign a_we_o        = a_we_q;
  assign b_we_o        = b_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign calc_start_o  = calc_start_q;
  assign res_addr_o    = res_addr_q;
  assign matrix_size_o = matrix_size_q;
  assign state_o       = state_q;
  assign busy_o        = busy_q;
  assign size_err_o    = size_err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: models the A/B memories, the
// calculator and uart_tx, and checks writes and TX bytes against queues.
module tb_matmul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_busy;
  logic        calc_done = 1'b0;
  logic [15:0] res_data = '0;

  logic        tx_start, a_we, b_we, calc_start, busy, size_err;
  logic [7:0]  tx_data, mem_wdata;
  logic [3:0]  mem_addr, res_addr, matrix_size;
  logic [2:0]  state;

  matmul_sequencer #(
    .MaxN (3),
    .DataW(8),
    .ResW (16),
    .AddrW(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .tx_busy_i    (tx_busy),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .a_we_o       (a_we),
    .b_we_o       (b_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .calc_start_o (calc_start),
    .calc_done_i  (calc_done),
    .res_addr_o   (res_addr),
    .res_data_i   (res_data),
    .matrix_size_o(matrix_size),
    .state_o      (state),
    .busy_o       (busy),
    .size_err_o   (size_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] we;    // {a_we, b_we}
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  mem_a[0:15];
  logic [7:0]  mem_b[0:15];
  logic [15:0] res_mem[0:15];
  logic [7:0]  stim_a[0:8];
  logic [7:0]  stim_b[0:8];
  int          busy_cnt = 0;
  int          busy_hold = 10;
  int          calc_cnt = 0;
  int          calc_starts = 0;
  bit          calc_fixed = 1'b0;
  int          cur_n = 1;

  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Calculator stub: real product of what landed in memory, or a fixed pattern.
  function automatic logic [15:0] stub_val(input int a);
    int          i = a / 3;
    int          j = a % 3;
    logic [31:0] s = '0;
    if (calc_fixed) return 16'h0100 + 16'(a);
    for (int k = 0; k < cur_n; k++) s += 32'(mem_a[i*3+k]) * 32'(mem_b[k*3+j]);
    return s[15:0];
  endfunction

  // Reference result from the host-side matrices (row-major n x n).
  function automatic logic [15:0] exp_val(input int n, input int i, input int j);
    logic [31:0] s = '0;
    if (calc_fixed) return 16'h0100 + 16'(i*3 + j);
    for (int k = 0; k < n; k++) s += 32'(stim_a[i*n+k]) * 32'(stim_b[k*n+j]);
    return s[15:0];
  endfunction

  // Environment models: uart_tx busy timer, A/B/result memories, calculator.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_hold;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (a_we) mem_a[mem_addr] <= mem_wdata;
    if (b_we) mem_b[mem_addr] <= mem_wdata;
    res_data  <= res_mem[res_addr];
    calc_done <= 1'b0;
    if (calc_start) calc_cnt <= 10;
    else if (calc_cnt != 0) begin
      calc_cnt <= calc_cnt - 1;
      if (calc_cnt == 1) begin
        calc_done <= 1'b1;
        for (int a = 0; a < 9; a++) res_mem[a] <= stub_val(a);
      end
    end
  end

  // Monitor: pop and compare on every memory write and every TX byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_we || b_we) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'({a_we, b_we}), 32'd0);
        else begin
          chk("wr_we", 32'({a_we, b_we}), 32'(exp_wr[0].we));
          chk("wr_addr", 32'(mem_addr), 32'(exp_wr[0].addr));
          chk("wr_data", 32'(mem_wdata), 32'(exp_wr[0].data));
          void'(exp_wr.pop_front());
        end
      end
      if (tx_start) begin
        chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
        if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        else begin
          chk("tx_data", 32'(tx_data), 32'(exp_tx[0]));
          void'(exp_tx.pop_front());
        end
      end
      if (calc_start) calc_starts <= calc_starts + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Queue the expected traffic of an n x n job, then send its first nbytes bytes.
  task automatic load_job(input int n, input int nbytes);
    int          sent = 0;
    logic [15:0] v;
    cur_n = n;
    for (int a = 0; a < 9; a++) exp_wr.push_back(wr_t'{2'b11, 4'(a), 8'h00});
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) exp_wr.push_back(wr_t'{2'b10, 4'(i*3+j), stim_a[i*n+j]});
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) exp_wr.push_back(wr_t'{2'b01, 4'(i*3+j), stim_b[i*n+j]});
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        v = exp_val(n, i, j);
        exp_tx.push_back(v[15:8]);
        exp_tx.push_back(v[7:0]);
      end
    send_byte(8'(n));
    sent++;
    repeat (10) @(negedge clk);
    chk("size_err_cleared", 32'(size_err), 32'd0);
    chk("matrix_size", 32'(matrix_size), 32'(n));
    for (int e = 0; e < 2*n*n; e++) begin
      if (sent < nbytes) begin
        send_byte(e < n*n ? stim_a[e] : stim_b[e-n*n]);
        sent++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic run_job(input int n, input bit inject);
    int base = calc_starts;
    bit done = 1'b0;
    load_job(n, 1 + 2*n*n);
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (inject && state == 3'd5 && $urandom_range(0, 3) == 0) begin
        rx_data  = 8'($urandom);
        rx_valid = 1'b1;
      end else rx_valid = 1'b0;
      if (!busy) done = 1'b1;
    end
    rx_valid = 1'b0;
    chk("job_done", 32'(done), 32'd1);
    chk("tx_bytes_left", 32'(exp_tx.size()), 32'd0);
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
    chk("calc_start_pulses", 32'(calc_starts - base), 32'd1);
  endtask

  task automatic rand_stim();
    for (int a = 0; a < 9; a++) begin
      stim_a[a] = 8'($urandom);
      stim_b[a] = 8'($urandom);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rx_data  = 8'($urandom);
      rx_valid = 1'($urandom_range(0, 1));
    end
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_a_we", 32'(a_we), 32'd0);
    chk("rst_b_we", 32'(b_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_calc_start", 32'(calc_start), 32'd0);
    chk("rst_res_addr", 32'(res_addr), 32'd0);
    chk("rst_matrix_size", 32'(matrix_size), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_size_err", 32'(size_err), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Illegal size bytes leave the block idle with the sticky error set.
    send_byte(8'h00);
    chk("size_err_zero", 32'(size_err), 32'd1);
    send_byte(8'h04);
    chk("size_err_four", 32'(size_err), 32'd1);
    chk("illegal_state", 32'(state), 32'd0);
    chk("illegal_busy", 32'(busy), 32'd0);

    // 2x2 known matrices.
    for (int a = 0; a < 4; a++) begin
      stim_a[a] = 8'(a + 1);
      stim_b[a] = 8'(a + 5);
    end
    run_job(2, 1'b0);

    // 3x3 fixed result pattern.
    calc_fixed = 1'b1;
    busy_hold  = 12;
    rand_stim();
    run_job(3, 1'b0);

    // Heavy back-pressure with stray RX bytes during SEND.
    calc_fixed = 1'b0;
    busy_hold  = 50;
    rand_stim();
    run_job(3, 1'b1);

    // tx_busy never rises: the timeout path must still deliver every byte.
    busy_hold = 0;
    rand_stim();
    run_job(2, 1'b0);

    for (int r = 0; r < 3; r++) begin
      busy_hold = $urandom_range(2, 20);
      rand_stim();
      run_job($urandom_range(1, 3), 1'b1);
    end

    // Reset in the middle of RX_B, then a 1x1 job.
    busy_hold = 8;
    rand_stim();
    load_job(3, 1 + 9 + 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_b_we", 32'(b_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_wr.delete();
    exp_tx.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stim_a[0] = 8'd7;
    stim_b[0] = 8'd9;
    run_job(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule
